// File: rtl/op_config_pkg.sv
// Shared types and widths for the pushbutton/switch configuration controller
// that drives the ALU and barrel-shifter op/amount inputs.
package op_config_pkg;

   typedef enum logic [1:0] {
      TGT_ALU    = 2'd0,
      TGT_BS_OP  = 2'd1,
      TGT_BS_AMT = 2'd2
   } tgt_t;

   localparam int ALU_OP_W = 2;
   localparam int BS_OP_W  = 2;
   localparam int BS_AMT_W = 3;

   // 10 ms of stable samples at 100 MHz
   localparam int DB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/op_config_ctrl_btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw pushbutton.
// Emits a single-cycle pulse when the debounced level rises.
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pulse;
   logic             w_flip;

   assign w_flip  = (r_sync2 != r_state) && (r_cnt == CNT_MAX);
   assign o_pulse = r_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= 1'b0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_pulse <= w_flip && r_sync2;
         // Any agreement with the debounced level restarts the stability window
         if (r_sync2 == r_state) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_state <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/op_config_ctrl.sv
// Target-select FSM and configuration registers for the ALU/barrel-shifter,
// driven by debounced next/load buttons and synchronized slide switches.
module op_config_ctrl
   import op_config_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                btn_next,
   input  logic                btn_load,
   input  logic [2:0]          sw,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [BS_OP_W-1:0]  bs_op,
   output logic [BS_AMT_W-1:0] bs_amt,
   output logic [1:0]          target,
   output logic                cfg_update
);

   logic [1:0]          w_btn_raw;
   logic [1:0]          w_btn_pulse;
   logic                w_next_p;
   logic                w_load_p;
   logic [2:0]          r_sw_s1;
   logic [2:0]          r_sw_s2;
   logic [1:0]          r_target;
   logic [1:0]          w_target_next;
   logic [ALU_OP_W-1:0] r_alu_op;
   logic [BS_OP_W-1:0]  r_bs_op;
   logic [BS_AMT_W-1:0] r_bs_amt;
   logic                r_cfg_update;

   assign w_btn_raw = {btn_load, btn_next};
   assign w_next_p  = w_btn_pulse[0];
   assign w_load_p  = w_btn_pulse[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_db
         btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
         ) u_db (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (w_btn_raw[gi]),
            .o_pulse(w_btn_pulse[gi])
         );
      end
   endgenerate

   always_comb begin
      w_target_next = r_target;
      case (r_target)
         TGT_ALU:    if (w_next_p) w_target_next = TGT_BS_OP;
         TGT_BS_OP:  if (w_next_p) w_target_next = TGT_BS_AMT;
         TGT_BS_AMT: if (w_next_p) w_target_next = TGT_ALU;
         default:    w_target_next = TGT_ALU;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sw_s1      <= '0;
         r_sw_s2      <= '0;
         r_target     <= TGT_ALU;
         r_alu_op     <= '0;
         r_bs_op      <= '0;
         r_bs_amt     <= '0;
         r_cfg_update <= 1'b0;
      end else begin
         r_sw_s1      <= sw;
         r_sw_s2      <= r_sw_s1;
         r_target     <= w_target_next;
         r_cfg_update <= w_load_p;
         // Commit uses the pre-advance target when next and load coincide
         if (w_load_p) begin
            case (r_target)
               TGT_ALU:    r_alu_op <= r_sw_s2[ALU_OP_W-1:0];
               TGT_BS_OP:  r_bs_op  <= r_sw_s2[BS_OP_W-1:0];
               TGT_BS_AMT: r_bs_amt <= r_sw_s2[BS_AMT_W-1:0];
               default:    ;
            endcase
         end
      end
   end

   assign alu_op     = r_alu_op;
   assign bs_op      = r_bs_op;
   assign bs_amt     = r_bs_amt;
   assign target     = r_target;
   assign cfg_update = r_cfg_update;

endmodule

// File: tb/tb_op_config_ctrl.sv
// Directed bench for op_config_ctrl with DB_CYCLES=4; expected register
// snapshots are queued at each load and checked whenever cfg_update fires.
module tb_op_config_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_next = 1'b0;
   logic       btn_load = 1'b0;
   logic [2:0] sw = 3'd0;
   logic [1:0] alu_op;
   logic [1:0] bs_op;
   logic [2:0] bs_amt;
   logic [1:0] target;
   logic       cfg_update;

   int n_checks = 0;
   int n_fail   = 0;

   // {alu_op, bs_op, bs_amt, target}
   logic [8:0] exp_q[$];

   op_config_ctrl #(.DB_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_next  (btn_next),
      .btn_load  (btn_load),
      .sw        (sw),
      .alu_op    (alu_op),
      .bs_op     (bs_op),
      .bs_amt    (bs_amt),
      .target    (target),
      .cfg_update(cfg_update)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [1:0] a, input logic [1:0] b,
                           input logic [2:0] m, input logic [1:0] t);
      exp_q.push_back({a, b, m, t});
   endtask

   task automatic press_next();
      btn_next = 1'b1;
      step(10);
      btn_next = 1'b0;
      step(10);
   endtask

   task automatic press_load();
      btn_load = 1'b1;
      step(10);
      btn_load = 1'b0;
      step(10);
   endtask

   // Monitor: every cfg_update pulse must match the oldest queued snapshot
   always @(negedge clk) begin
      if (!rst && cfg_update) begin
         logic [8:0] act;
         logic [8:0] exp;
         act = {alu_op, bs_op, bs_amt, target};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL cfg_update_unexpected: got alu=%0d bs_op=%0d amt=%0d tgt=%0d expected no update",
                     alu_op, bs_op, bs_amt, target);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               n_fail++;
               $display("FAIL cfg_commit: got %h expected %h", act, exp);
            end else begin
               $display("ok   cfg_commit: alu=%0d bs_op=%0d amt=%0d tgt=%0d",
                        alu_op, bs_op, bs_amt, target);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset
      step(2);
      rst = 1'b0;
      step(1);
      chk("reset_alu_op", alu_op, 0);
      chk("reset_bs_op", bs_op, 0);
      chk("reset_bs_amt", bs_amt, 0);
      chk("reset_target", target, 0);
      chk("reset_cfg_update", cfg_update, 0);
      step(10);
      chk("idle_hold", {alu_op, bs_op, bs_amt, target, cfg_update}, 0);

      // Load timing: edge k is the first step after raising btn_load
      sw = 3'b101;
      step(3);
      push_exp(2'b01, 2'b00, 3'b000, 2'd0);
      btn_load = 1'b1;
      step(6);                                   // edge k+5
      chk("load_before_k6_alu", alu_op, 0);
      chk("load_before_k6_cfg", cfg_update, 0);
      step(1);                                   // edge k+6
      chk("load_k6_alu", alu_op, 1);
      chk("load_k6_cfg", cfg_update, 1);
      chk("load_k6_target", target, 0);
      step(1);
      chk("load_k7_cfg_clear", cfg_update, 0);
      step(10);
      btn_load = 1'b0;
      step(12);
      chk("load_held_target", target, 0);

      // Full sequence
      press_next();
      chk("seq_target1", target, 1);
      sw = 3'b010;
      step(3);
      push_exp(2'b01, 2'b10, 3'b000, 2'd1);
      press_load();
      press_next();
      chk("seq_target2", target, 2);
      sw = 3'b110;
      step(3);
      push_exp(2'b01, 2'b10, 3'b110, 2'd2);
      press_load();
      press_next();
      chk("seq_bs_op", bs_op, 2);
      chk("seq_bs_amt", bs_amt, 6);
      chk("seq_alu_op", alu_op, 1);
      chk("seq_target_wrap", target, 0);

      // Bounce rejection
      btn_next = 1'b1; step(1);
      btn_next = 1'b0; step(1);
      btn_next = 1'b1; step(1);
      btn_next = 1'b0; step(12);
      chk("bounce_target", target, 0);

      // Simultaneous press from TGT_BS_AMT
      press_next();
      press_next();
      chk("simul_setup_target", target, 2);
      sw = 3'b111;
      step(3);
      push_exp(2'b01, 2'b10, 3'b111, 2'd0);
      btn_next = 1'b1;
      btn_load = 1'b1;
      step(6);                                   // edge k+5
      chk("simul_k5_amt", bs_amt, 6);
      chk("simul_k5_target", target, 2);
      step(1);                                   // edge k+6
      chk("simul_k6_amt", bs_amt, 7);
      chk("simul_k6_target", target, 0);
      chk("simul_k6_cfg", cfg_update, 1);
      step(1);
      chk("simul_k7_cfg_clear", cfg_update, 0);
      btn_next = 1'b0;
      btn_load = 1'b0;
      step(12);

      // Reset mid-debounce with button held through reset
      sw = 3'b011;
      step(3);
      btn_load = 1'b1;
      step(3);                                   // edge k+2
      chk("rstmid_no_commit", alu_op, 1);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      push_exp(2'b11, 2'b00, 3'b000, 2'd0);
      step(1);                                   // edge r
      chk("rstmid_reset_alu", alu_op, 0);
      chk("rstmid_reset_amt", bs_amt, 0);
      step(5);                                   // edge r+5
      chk("rstmid_r5_alu", alu_op, 0);
      step(1);                                   // edge r+6
      chk("rstmid_r6_alu", alu_op, 3);
      chk("rstmid_r6_cfg", cfg_update, 1);
      step(20);
      btn_load = 1'b0;
      step(12);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
